// File: rtl/i2s_rx_tdm.sv
`default_nettype none
// ============================================================================
// Module : i2s_rx_tdm
// Desc   : I2S / left-justified / TDM serial-audio receiver with frame checks.
// Rev    : 1.0
// ============================================================================
module i2s_rx_tdm #(
  parameter int  BITS      = 24,
  parameter int  SLOT_BITS = 32,
  parameter int  CHANNELS  = 2,
  localparam int CW        = $clog2(CHANNELS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            mode_lj,
  input  logic            bck,
  input  logic            lrck,
  input  logic            data,
  output logic [BITS-1:0] sample,
  output logic [CW-1:0]   chan,
  output logic            valid,
  output logic            frame_err
);

  localparam int            c_bw        = $clog2(SLOT_BITS);
  localparam logic [c_bw-1:0] c_slot_last = c_bw'(SLOT_BITS - 1);
  localparam logic [c_bw-1:0] c_word_last = c_bw'(BITS - 1);
  localparam logic [CW-1:0]   c_ch_last   = CW'(CHANNELS - 1);
  localparam logic            c_half_en   = (CHANNELS == 2);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [1:0]      r_bck_sync, r_lrck_sync, r_data_sync;
  logic            r_bck_d, r_lrck_prev, r_pend_fall, r_pend_half;
  state_t          r_state, w_state_nx;
  logic [c_bw-1:0] r_bcnt, w_bcnt_nx, w_pos_b;
  logic [CW-1:0]   r_scnt, w_scnt_nx, w_pos_s;
  logic [BITS-1:0] r_shift, w_shift_nx;
  logic            w_rise, w_lr_fall, w_lr_rise, w_ss_frame, w_ss_half;
  logic            w_take, w_err, w_done, w_at_end, w_at_frame_end;

  assign w_rise     = r_bck_sync[1] & ~r_bck_d;
  assign w_lr_fall  = r_lrck_prev & ~r_lrck_sync[1];
  assign w_lr_rise  = c_half_en & ~r_lrck_prev & r_lrck_sync[1];
  // In I2S mode the slot starts one bck after the lrck edge.
  assign w_ss_frame = w_rise & (mode_lj ? w_lr_fall : r_pend_fall);
  assign w_ss_half  = w_rise & (mode_lj ? w_lr_rise : r_pend_half);

  assign w_at_end       = (r_bcnt == c_slot_last);
  assign w_at_frame_end = w_at_end && (r_scnt == c_ch_last);

  // Counters hold the slot position of the bit most recently captured.
  always_comb begin
    w_state_nx = r_state;
    w_bcnt_nx  = r_bcnt;
    w_scnt_nx  = r_scnt;
    w_pos_b    = r_bcnt;
    w_pos_s    = r_scnt;
    w_take     = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      HUNT: begin
        w_bcnt_nx = '0;
        w_scnt_nx = '0;
        if (enable && w_ss_frame) begin
          w_state_nx = RUN;
          w_take     = 1'b1;
          w_pos_b    = '0;
          w_pos_s    = '0;
        end
      end
      RUN: begin
        if (!enable) begin
          w_state_nx = HUNT;
          w_bcnt_nx  = '0;
          w_scnt_nx  = '0;
        end else if (w_rise) begin
          w_take = 1'b1;
          if (w_ss_frame) begin
            // A misplaced frame edge is still a valid restart point.
            w_pos_b = '0;
            w_pos_s = '0;
            w_err   = !w_at_frame_end;
          end else if ((w_ss_half && !(w_at_end && r_scnt == '0)) || w_at_frame_end) begin
            w_err      = 1'b1;
            w_take     = 1'b0;
            w_state_nx = HUNT;
            w_bcnt_nx  = '0;
            w_scnt_nx  = '0;
          end else if (w_at_end) begin
            w_pos_b = '0;
            w_pos_s = r_scnt + 1'b1;
          end else begin
            w_pos_b = r_bcnt + 1'b1;
          end
          if (w_take) begin
            w_bcnt_nx = w_pos_b;
            w_scnt_nx = w_pos_s;
          end
        end
      end
      default: w_state_nx = HUNT;
    endcase

    w_shift_nx = r_shift;
    if (w_take && (32'(w_pos_b) < BITS)) begin
      w_shift_nx = BITS'({r_shift, r_data_sync[1]});
    end
    w_done = w_take && !w_err && (w_pos_b == c_word_last);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bck_sync  <= '0;
      r_lrck_sync <= '0;
      r_data_sync <= '0;
      r_bck_d     <= 1'b0;
      r_lrck_prev <= 1'b0;
      r_pend_fall <= 1'b0;
      r_pend_half <= 1'b0;
      r_state     <= HUNT;
      r_bcnt      <= '0;
      r_scnt      <= '0;
      r_shift     <= '0;
      sample      <= '0;
      chan        <= '0;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      r_bck_sync  <= {r_bck_sync[0], bck};
      r_lrck_sync <= {r_lrck_sync[0], lrck};
      r_data_sync <= {r_data_sync[0], data};
      r_bck_d     <= r_bck_sync[1];
      if (w_rise) begin
        r_lrck_prev <= r_lrck_sync[1];
        r_pend_fall <= w_lr_fall;
        r_pend_half <= w_lr_rise;
      end
      r_state   <= w_state_nx;
      r_bcnt    <= w_bcnt_nx;
      r_scnt    <= w_scnt_nx;
      r_shift   <= w_shift_nx;
      valid     <= w_done;
      frame_err <= w_err;
      if (w_done) begin
        sample <= w_shift_nx;
        chan   <= w_pos_s;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_tdm.sv
`default_nettype none
// ============================================================================
// Module : tb_i2s_rx_tdm
// Desc   : Directed self-checking bench for i2s_rx_tdm (2-channel and TDM-4).
// Rev    : 1.0
// ============================================================================
module tb_i2s_rx_tdm;

  logic        clk = 1'b0;
  logic        reset_n, enable, mode_lj, bck, lrck, data;
  logic [23:0] sample2, sample4;
  logic        chan2;
  logic [1:0]  chan4;
  logic        valid2, valid4, ferr2, ferr4;

  int          cyc = 0;
  int          n_total = 0;
  int          n_pass = 0;
  int          n_err2 = 0;
  int          n_err4 = 0;
  int          n_both = 0;
  int          e4;
  int          rc [128];
  logic [23:0] w [4];
  logic [31:0] q_ch2[$], q_s2[$], q_ch4[$], q_s4[$];
  int          q_cy2[$];

  i2s_rx_tdm #(.BITS(24), .SLOT_BITS(32), .CHANNELS(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode_lj(mode_lj),
    .bck(bck), .lrck(lrck), .data(data),
    .sample(sample2), .chan(chan2), .valid(valid2), .frame_err(ferr2)
  );

  i2s_rx_tdm #(.BITS(24), .SLOT_BITS(32), .CHANNELS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode_lj(mode_lj),
    .bck(bck), .lrck(lrck), .data(data),
    .sample(sample4), .chan(chan4), .valid(valid4), .frame_err(ferr4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid2) begin
      q_ch2.push_back(32'(chan2));
      q_s2.push_back(32'(sample2));
      q_cy2.push_back(cyc);
    end
    if (ferr2) n_err2++;
    if (valid2 && ferr2) n_both++;
    if (valid4) begin
      q_ch4.push_back(32'(chan4));
      q_s4.push_back(32'(sample4));
    end
    if (ferr4) n_err4++;
    if (valid4 && ferr4) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One bck period: 4 clk low then 4 clk high; lrck/data change with bck low.
  task automatic bit_out(input logic l, input logic d, input int idx);
    bck = 1'b0; lrck = l; data = d;
    repeat (4) @(negedge clk);
    bck = 1'b1; rc[idx] = cyc;
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input int first, input int last, input logic tdm, input logic lj);
    for (int i = first; i <= last; i++) begin
      logic l;
      logic d;
      int   k;
      l = tdm ? (i == 127) : (i >= 32);
      k = lj ? i : i - 1;
      d = 1'b0;
      if (k >= 0 && (k % 32) < 24) d = w[k / 32][23 - (k % 32)];
      bit_out(l, d, i);
    end
  endtask

  task automatic pop2(input string tag, input int ch, input int s, input int ecyc);
    int c;
    chk({tag, " present"}, 32'(q_ch2.size() > 0), 1);
    if (q_ch2.size() > 0) begin
      chk({tag, " chan"}, q_ch2.pop_front(), ch);
      chk({tag, " sample"}, q_s2.pop_front(), s);
      c = q_cy2.pop_front();
      if (ecyc >= 0) chk({tag, " latency"}, c, ecyc);
    end
  endtask

  task automatic pop4(input string tag, input int ch, input int s);
    chk({tag, " present"}, 32'(q_ch4.size() > 0), 1);
    if (q_ch4.size() > 0) begin
      chk({tag, " chan"}, q_ch4.pop_front(), ch);
      chk({tag, " sample"}, q_s4.pop_front(), s);
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; mode_lj = 1'b0;
    bck = 1'b0; lrck = 1'b0; data = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst sample", sample2, 0);
    chk("rst chan", chan2, 0);
    chk("rst valid", valid2, 0);
    chk("rst frame_err", ferr2, 0);
    chk("rst sample4", sample4, 0);
    reset_n = 1'b1; enable = 1'b1;

    // Startup mid-frame, I2S
    w = '{24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0};
    send(40, 63, 1'b0, 1'b0);
    chk("startup no valid", q_ch2.size(), 0);
    w = '{24'h123456, 24'h654321, 24'h0, 24'h0};
    send(0, 63, 1'b0, 1'b0);
    pop2("start L", 0, 'h123456, rc[24] + 3);
    pop2("start R", 1, 'h654321, rc[56] + 3);

    // I2S steady state
    w = '{24'hA5A5A5, 24'h5A5A5A, 24'h0, 24'h0};
    for (int f = 0; f < 2; f++) begin
      send(0, 63, 1'b0, 1'b0);
      pop2("i2s L", 0, 'hA5A5A5, rc[24] + 3);
      pop2("i2s R", 1, 'h5A5A5A, rc[56] + 3);
    end
    chk("i2s ferr count", n_err2, 0);

    // Left-justified: words one bck earlier
    enable = 1'b0;
    repeat (4) @(negedge clk);
    mode_lj = 1'b1; enable = 1'b1;
    for (int f = 0; f < 2; f++) begin
      send(0, 63, 1'b0, 1'b1);
      pop2("lj L", 0, 'hA5A5A5, rc[23] + 3);
      pop2("lj R", 1, 'h5A5A5A, rc[55] + 3);
    end
    chk("lj ferr count", n_err2, 0);

    // Short frame (48 bck) then resync
    w = '{24'h0F0F0F, 24'hF0F0F0, 24'h0, 24'h0};
    send(0, 47, 1'b0, 1'b1);
    pop2("short L", 0, 'h0F0F0F, -1);
    chk("short no R", q_ch2.size(), 0);
    w = '{24'hC3C3C3, 24'h3C3C3C, 24'h0, 24'h0};
    send(0, 63, 1'b0, 1'b1);
    chk("short ferr count", n_err2, 1);
    pop2("resync L", 0, 'hC3C3C3, -1);
    pop2("resync R", 1, 'h3C3C3C, -1);

    // Reset pulse during slot 0
    w = '{24'h13579B, 24'h2468AC, 24'h0, 24'h0};
    send(0, 9, 1'b0, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst pulse sample", sample2, 0);
    send(10, 63, 1'b0, 1'b1);
    chk("rst pulse no valid", q_ch2.size(), 0);
    send(0, 63, 1'b0, 1'b1);
    pop2("post rst L", 0, 'h13579B, -1);
    pop2("post rst R", 1, 'h2468AC, -1);

    // Enable low for roughly 10 us mid-frame
    send(0, 15, 1'b0, 1'b1);
    enable = 1'b0;
    send(16, 63, 1'b0, 1'b1);
    send(0, 63, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    chk("disabled no valid", q_ch2.size(), 0);
    enable = 1'b1;
    send(0, 63, 1'b0, 1'b1);
    pop2("re-enable L", 0, 'h13579B, -1);
    pop2("re-enable R", 1, 'h2468AC, -1);

    // TDM-4, one-bck lrck pulse ending at frame start
    enable = 1'b0;
    repeat (4) @(negedge clk);
    q_ch4.delete();
    q_s4.delete();
    e4 = n_err4;
    enable = 1'b1;
    w = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
    for (int f = 0; f < 2; f++) begin
      send(0, 127, 1'b1, 1'b1);
      for (int s = 0; s < 4; s++) pop4("tdm slot", s, 32'(w[s]));
    end
    chk("tdm ferr count", n_err4 - e4, 0);
    chk("valid/frame_err overlap", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
